// File: rtl/spi_write_pkg.sv
// Shared definitions for the SPI write controller: state encodings,
// default widths and the SPI mode the controller drives.
package spi_write_pkg;

   localparam int DefaultDataWidth = 24;
   localparam int DefaultDivWidth  = 8;

   // Mode 0: CPOL=0 (sclk idles low), CPHA=0 (slave samples on the rising edge)
   localparam int   SpiMode  = 0;
   localparam logic SclkIdle = SpiMode[1];

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StSetup   = 3'd1;
   localparam logic [2:0] StShiftHi = 3'd2;
   localparam logic [2:0] StShiftLo = 3'd3;
   localparam logic [2:0] StHold    = 3'd4;
   localparam logic [2:0] StGap     = 3'd5;

   typedef enum logic [2:0] {
      IDLE     = StIdle,
      SETUP    = StSetup,
      SHIFT_HI = StShiftHi,
      SHIFT_LO = StShiftLo,
      HOLD     = StHold,
      GAP      = StGap
   } spiState_e;

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: counts D = div+1 cycles per phase and ticks on the last
// cycle of each phase. A restart reloads it with the divider of a new frame.
module spi_half_tick
   import spi_write_pkg::*;
#(
   parameter int DivWidth = DefaultDivWidth
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                en_i,
   input  logic                restart_i,
   input  logic [DivWidth-1:0] restartDiv_i,
   input  logic [DivWidth-1:0] reloadDiv_i,
   output logic                tick_o
);

   logic [DivWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (restart_i) begin
         count_d = restartDiv_i;
      end else if (en_i) begin
         if (count_q == '0) begin
            count_d = reloadDiv_i;
         end else begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = en_i & (count_q == '0);

endmodule

// File: rtl/spi_write_ctrl.sv
// SPI write controller: one DataWidth-bit word per frame, MSB first, mode 0.
// Optional SPI_WRITE_HOLD_REG_EN adds a one-entry holding register for back-to-back frames.
module spi_write_ctrl
   import spi_write_pkg::*;
#(
   parameter int DataWidth = DefaultDataWidth,
   parameter int DivWidth  = DefaultDivWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 start_i,
   input  logic [DataWidth-1:0] data_i,
   input  logic [DivWidth-1:0]  div_i,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 sclk_o,
   output logic                 cs_no,
   output logic                 mosi_o
);

   localparam int CntWidth = $clog2(DataWidth + 1);

   spiState_e            state_q;
   logic [DataWidth-1:0] shift_q;
   logic [DivWidth-1:0]  div_q;
   logic [CntWidth-1:0]  bitCnt_q, bitCnt_d;
   logic                 sclk_q, csn_q, mosi_q, busy_q, done_q;
   logic                 tick;

   logic                 launch_d;
   logic [DataWidth-1:0] launchData_d;
   logic [DivWidth-1:0]  launchDiv_d;

`ifdef SPI_WRITE_HOLD_REG_EN
   logic                 holdValid_q;
   logic [DataWidth-1:0] holdData_q;
   logic [DivWidth-1:0]  holdDiv_q;

   // A frame starts from IDLE, or straight out of GAP when a word is waiting
   always_comb begin
      launch_d     = 1'b0;
      launchData_d = data_i;
      launchDiv_d  = div_i;
      if (state_q == IDLE) begin
         launch_d = start_i;
      end else if ((state_q == GAP) && tick) begin
         if (holdValid_q) begin
            launch_d     = 1'b1;
            launchData_d = holdData_q;
            launchDiv_d  = holdDiv_q;
         end else begin
            launch_d = start_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         holdValid_q <= 1'b0;
         holdData_q  <= '0;
         holdDiv_q   <= '0;
      end else if (launch_d && holdValid_q) begin
         holdValid_q <= 1'b0;
      end else if (busy_q && start_i && !holdValid_q && !launch_d) begin
         holdValid_q <= 1'b1;
         holdData_q  <= data_i;
         holdDiv_q   <= div_i;
      end
   end

   assign ready_o = ~holdValid_q;
`else
   always_comb begin
      launch_d     = (state_q == IDLE) && start_i;
      launchData_d = data_i;
      launchDiv_d  = div_i;
   end

   assign ready_o = ~busy_q;
`endif

   assign bitCnt_d = bitCnt_q + 1'b1;

   spi_half_tick #(
      .DivWidth (DivWidth)
   ) u_half_tick (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .en_i         (state_q != IDLE),
      .restart_i    (launch_d),
      .restartDiv_i (launchDiv_d),
      .reloadDiv_i  (div_q),
      .tick_o       (tick)
   );

   // mosi is refreshed with the next bit on the falling sclk edge so it is
   // stable well before the slave samples on the following rising edge
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         div_q    <= '0;
         bitCnt_q <= '0;
         sclk_q   <= SclkIdle;
         csn_q    <= 1'b1;
         mosi_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= (state_q == GAP) && tick;
         if (launch_d) begin
            state_q  <= SETUP;
            shift_q  <= launchData_d;
            div_q    <= launchDiv_d;
            bitCnt_q <= '0;
            sclk_q   <= SclkIdle;
            csn_q    <= 1'b0;
            mosi_q   <= launchData_d[DataWidth-1];
            busy_q   <= 1'b1;
         end else if (tick) begin
            case (state_q)
               SETUP: begin
                  state_q <= SHIFT_HI;
                  sclk_q  <= ~SclkIdle;
               end
               SHIFT_HI: begin
                  state_q <= SHIFT_LO;
                  sclk_q  <= SclkIdle;
                  mosi_q  <= shift_q[DataWidth-2];
               end
               SHIFT_LO: begin
                  shift_q  <= shift_q << 1;
                  bitCnt_q <= bitCnt_d;
                  if (bitCnt_d == CntWidth'(DataWidth)) begin
                     state_q <= HOLD;
                  end else begin
                     state_q <= SHIFT_HI;
                     sclk_q  <= ~SclkIdle;
                  end
               end
               HOLD: begin
                  state_q <= GAP;
                  csn_q   <= 1'b1;
                  mosi_q  <= 1'b0;
               end
               GAP: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign sclk_o = sclk_q;
   assign cs_no  = csn_q;
   assign mosi_o = mosi_q & ~csn_q;

endmodule

// File: tb/tb_spi_write_ctrl.sv
// Directed self-checking bench for spi_write_ctrl: frame timing, bit order,
// mid-frame reset, ignored starts, held start and (when enabled) the holding register.
module tb_spi_write_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start_i;
   logic [23:0] data_i;
   logic [7:0]  div_i;
   logic        ready_o, busy_o, done_o, sclk_o, cs_no, mosi_o;

   int checks   = 0;
   int failures = 0;

   logic [47:0] capWord;
   int riseCount, firstRise, secondRise, prevRise, lastRise;
   int csLowCycles, busyCycles, doneCount;
   int tailCsLow, tailBusy, tailDone;
   logic timedOut;

   spi_write_ctrl u_dut (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .start_i (start_i),
      .data_i  (data_i),
      .div_i   (div_i),
      .ready_o (ready_o),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .sclk_o  (sclk_o),
      .cs_no   (cs_no),
      .mosi_o  (mosi_o)
   );

   // 10 ns clock; inputs change and outputs are sampled on the falling edge
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Launches one frame and records its timing until done_o (or an abort)
   task automatic runFrame(input logic [23:0] data, input logic [7:0] div,
                           input int pokeCycle, input logic pokeStart,
                           input logic [23:0] pokeData, input logic [7:0] pokeDiv,
                           input int abortAfterRises);
      logic prevSclk;
      logic stop;
      int   cyc;
      capWord = '0; riseCount = 0; firstRise = 0; secondRise = 0;
      prevRise = 0; lastRise = 0; csLowCycles = 0; busyCycles = 0;
      doneCount = 0; timedOut = 1'b0;
      @(negedge clk);
      start_i = 1'b1; data_i = data; div_i = div;
      @(negedge clk);
      start_i = 1'b0;
      prevSclk = 1'b0;
      stop = 1'b0;
      cyc = 1;
      while (!stop) begin
         if (!cs_no) csLowCycles++;
         if (busy_o) busyCycles++;
         if (done_o) doneCount++;
         if (sclk_o && !prevSclk) begin
            riseCount++;
            capWord = {capWord[46:0], mosi_o};
            if (riseCount == 1) firstRise = cyc;
            if (riseCount == 2) secondRise = cyc;
            prevRise = lastRise;
            lastRise = cyc;
         end
         prevSclk = sclk_o;
         if (done_o || riseCount == abortAfterRises) begin
            stop = 1'b1;
         end else if (cyc >= 2000) begin
            timedOut = 1'b1;
            stop = 1'b1;
         end else begin
            if (cyc == pokeCycle) begin
               start_i = pokeStart; data_i = pokeData; div_i = pokeDiv;
            end else if (cyc == pokeCycle + 1) begin
               start_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
   endtask

   task automatic watchIdle(input int n);
      tailCsLow = 0; tailBusy = 0; tailDone = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!cs_no) tailCsLow++;
         if (busy_o) tailBusy++;
         if (done_o) tailDone++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; start_i = 1'b0; data_i = '0; div_i = '0;
      repeat (2) @(negedge clk);
      checks++; if (cs_no !== 1'b1)   begin failures++; $display("[TB] FAIL reset_cs got=%b exp=1", cs_no); end
      checks++; if (sclk_o !== 1'b0)  begin failures++; $display("[TB] FAIL reset_sclk got=%b exp=0", sclk_o); end
      checks++; if (mosi_o !== 1'b0)  begin failures++; $display("[TB] FAIL reset_mosi got=%b exp=0", mosi_o); end
      checks++; if (busy_o !== 1'b0)  begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy_o); end
      checks++; if (done_o !== 1'b0)  begin failures++; $display("[TB] FAIL reset_done got=%b exp=0", done_o); end
      checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=1", ready_o); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic_frame;
      runFrame(24'hA5F00F, 8'd0, -1, 1'b0, 24'h0, 8'd0, -1);
      checks++; if (timedOut !== 1'b0)         begin failures++; $display("[TB] FAIL basic_timeout got=%b exp=0", timedOut); end
      checks++; if (capWord[23:0] !== 24'hA5F00F) begin failures++; $display("[TB] FAIL basic_data got=%h exp=a5f00f", capWord[23:0]); end
      checks++; if (riseCount !== 24)          begin failures++; $display("[TB] FAIL basic_rises got=%0d exp=24", riseCount); end
      checks++; if (csLowCycles !== 50)        begin failures++; $display("[TB] FAIL basic_cs_low got=%0d exp=50", csLowCycles); end
      checks++; if (busyCycles !== 51)         begin failures++; $display("[TB] FAIL basic_busy got=%0d exp=51", busyCycles); end
      checks++; if (secondRise - firstRise !== 2) begin failures++; $display("[TB] FAIL basic_period got=%0d exp=2", secondRise - firstRise); end
      checks++; if (busy_o !== 1'b0)           begin failures++; $display("[TB] FAIL basic_busy_at_done got=%b exp=0", busy_o); end
      watchIdle(4);
      checks++; if (doneCount + tailDone !== 1) begin failures++; $display("[TB] FAIL basic_done_pulses got=%0d exp=1", doneCount + tailDone); end
   endtask

   task automatic test_divider;
      runFrame(24'h000001, 8'd3, 30, 1'b0, 24'h000001, 8'd0, -1);
      checks++; if (timedOut !== 1'b0)            begin failures++; $display("[TB] FAIL div_timeout got=%b exp=0", timedOut); end
      checks++; if (capWord[23:0] !== 24'h000001) begin failures++; $display("[TB] FAIL div_data got=%h exp=000001", capWord[23:0]); end
      checks++; if (firstRise !== 5)              begin failures++; $display("[TB] FAIL div_first_rise got=%0d exp=5", firstRise); end
      checks++; if (secondRise - firstRise !== 8) begin failures++; $display("[TB] FAIL div_period got=%0d exp=8", secondRise - firstRise); end
      checks++; if (lastRise - prevRise !== 8)    begin failures++; $display("[TB] FAIL div_late_period got=%0d exp=8", lastRise - prevRise); end
      checks++; if (busyCycles !== 204)           begin failures++; $display("[TB] FAIL div_busy got=%0d exp=204", busyCycles); end
      checks++; if (csLowCycles !== 200)          begin failures++; $display("[TB] FAIL div_cs_low got=%0d exp=200", csLowCycles); end
      div_i = 8'd0;
      @(negedge clk);
   endtask

   task automatic test_midframe_reset;
      runFrame(24'hF0F0F0, 8'd0, -1, 1'b0, 24'h0, 8'd0, 10);
      checks++; if (riseCount !== 10) begin failures++; $display("[TB] FAIL rst_rises got=%0d exp=10", riseCount); end
      rst_n = 1'b0;
      #1;
      checks++; if (cs_no !== 1'b1)  begin failures++; $display("[TB] FAIL rst_mid_cs got=%b exp=1", cs_no); end
      checks++; if (sclk_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_sclk got=%b exp=0", sclk_o); end
      checks++; if (mosi_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_mosi got=%b exp=0", mosi_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy got=%b exp=0", busy_o); end
      checks++; if (done_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_done got=%b exp=0", done_o); end
      @(negedge clk);
      rst_n = 1'b1;
      runFrame(24'h9ABCDE, 8'd0, -1, 1'b0, 24'h0, 8'd0, -1);
      checks++; if (capWord[23:0] !== 24'h9ABCDE) begin failures++; $display("[TB] FAIL rst_resend_data got=%h exp=9abcde", capWord[23:0]); end
      checks++; if (busyCycles !== 51)            begin failures++; $display("[TB] FAIL rst_resend_busy got=%0d exp=51", busyCycles); end
   endtask

`ifndef SPI_WRITE_HOLD_REG_EN
   task automatic test_ignore_midframe;
      runFrame(24'h3C96E1, 8'd0, 20, 1'b1, 24'h123456, 8'd0, -1);
      checks++; if (capWord[23:0] !== 24'h3C96E1) begin failures++; $display("[TB] FAIL ignore_data got=%h exp=3c96e1", capWord[23:0]); end
      checks++; if (busyCycles !== 51)            begin failures++; $display("[TB] FAIL ignore_busy got=%0d exp=51", busyCycles); end
      watchIdle(6);
      checks++; if (doneCount + tailDone !== 1)   begin failures++; $display("[TB] FAIL ignore_done got=%0d exp=1", doneCount + tailDone); end
      checks++; if (tailCsLow !== 0)              begin failures++; $display("[TB] FAIL ignore_no_second_frame got=%0d exp=0", tailCsLow); end
   endtask

   task automatic test_back_to_back;
      int busyCount;
      busyCount = 0;
      @(negedge clk);
      start_i = 1'b1; data_i = 24'h5A5A5A; div_i = 8'd0;
      for (int k = 1; k <= 106; k++) begin
         @(negedge clk);
         if (k <= 103 && busy_o) busyCount++;
         if (k == 51) begin
            checks++; if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy_51 got=%b exp=1", busy_o); end
         end
         if (k == 52) begin
            checks++; if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle_busy got=%b exp=0", busy_o); end
            checks++; if (done_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle_done got=%b exp=1", done_o); end
         end
         if (k == 53) begin
            checks++; if (cs_no !== 1'b0)  begin failures++; $display("[TB] FAIL b2b_second_cs got=%b exp=0", cs_no); end
         end
         if (k == 103) start_i = 1'b0;
         if (k == 105) begin
            checks++; if (busy_o !== 1'b0 || cs_no !== 1'b1) begin failures++; $display("[TB] FAIL b2b_stop got=busy%b/cs%b exp=busy0/cs1", busy_o, cs_no); end
         end
      end
      checks++; if (busyCount !== 102) begin failures++; $display("[TB] FAIL b2b_busy_total got=%0d exp=102", busyCount); end
   endtask
`else
   task automatic test_hold_reg;
      int csHigh, busyLow, dones, rises;
      logic prevSclk;
      logic [47:0] bits;
      csHigh = 0; busyLow = 0; dones = 0; rises = 0; prevSclk = 1'b0; bits = '0;
      @(negedge clk);
      start_i = 1'b1; data_i = 24'h111111; div_i = 8'd1;
      for (int k = 1; k <= 210; k++) begin
         @(negedge clk);
         if (k == 1) start_i = 1'b0;
         if (k == 10) begin start_i = 1'b1; data_i = 24'h222222; end
         if (k == 11) begin
            start_i = 1'b0;
            checks++; if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL hold_ready_low got=%b exp=0", ready_o); end
         end
         if (k <= 202 && cs_no) csHigh++;
         if (k <= 204 && !busy_o) busyLow++;
         if (done_o) dones++;
         if (sclk_o && !prevSclk) begin rises++; bits = {bits[46:0], mosi_o}; end
         prevSclk = sclk_o;
         if (k == 103) begin
            checks++; if (done_o !== 1'b1 || busy_o !== 1'b1) begin failures++; $display("[TB] FAIL hold_first_done got=done%b/busy%b exp=done1/busy1", done_o, busy_o); end
            checks++; if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL hold_ready_back got=%b exp=1", ready_o); end
         end
         if (k == 205) begin
            checks++; if (done_o !== 1'b1 || busy_o !== 1'b0) begin failures++; $display("[TB] FAIL hold_second_done got=done%b/busy%b exp=done1/busy0", done_o, busy_o); end
         end
      end
      checks++; if (csHigh !== 2)   begin failures++; $display("[TB] FAIL hold_cs_gap got=%0d exp=2", csHigh); end
      checks++; if (busyLow !== 0)  begin failures++; $display("[TB] FAIL hold_busy_gap got=%0d exp=0", busyLow); end
      checks++; if (dones !== 2)    begin failures++; $display("[TB] FAIL hold_done_pulses got=%0d exp=2", dones); end
      checks++; if (rises !== 48)   begin failures++; $display("[TB] FAIL hold_rises got=%0d exp=48", rises); end
      checks++; if (bits !== 48'h111111222222) begin failures++; $display("[TB] FAIL hold_data got=%h exp=111111222222", bits); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic_frame();
      test_divider();
      test_midframe_reset();
`ifndef SPI_WRITE_HOLD_REG_EN
      test_ignore_midframe();
      test_back_to_back();
`else
      test_hold_reg();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_write_ctrl.md
# spi_write_ctrl

SPI write controller that serializes one DataWidth-bit word per transaction onto sclk_o/mosi_o/cs_no, sequencing the clock divider, bit counter and shift register. It sits between the host-side register interface (start/data handshake) and the external DAC/SPI pins in the SPI write IP. It owns frame timing: chip-select setup, shifting, hold and inter-frame gap.

## Interface
- DataWidth, 24, bits per frame, MSB first
- DivWidth, 8, width of the clock-divider setting
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- start_i  in  1  request a frame; accepted when ready_o=1
- data_i  in  DataWidth  word to send; sampled on the accept cycle
- div_i  in  DivWidth  half-period length minus one, D=div_i+1 clk cycles; sampled on accept
- ready_o  out  1  controller can accept start_i this cycle
- busy_o  out  1  frame in progress
- done_o  out  1  one-cycle pulse at frame completion
- sclk_o  out  1  SPI clock, idle low
- cs_no  out  1  chip select, active low
- mosi_o  out  1  serial data

## Operation
- SPI mode 0: slave samples mosi_o on the sclk_o rising edge; mosi_o changes only after a falling edge.
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP. Each non-IDLE state lasts exactly D cycles, timed by a half-period tick.
- IDLE: cs_no=1, sclk_o=0, mosi_o=0. On start_i&ready_o: load shift register with data_i, latch D, clear bit count, go to SETUP.
- SETUP: cs_no=0, sclk_o=0, mosi_o=shift MSB, then SHIFT_HI.
- SHIFT_HI: sclk_o=1, then SHIFT_LO.
- SHIFT_LO: sclk_o=0. At its end, shift left one bit and increment the bit count. If count==DataWidth, go to HOLD; otherwise go to SHIFT_HI.
- HOLD: cs_no=0, sclk_o=0, then GAP.
- GAP: cs_no=1. At its end, pulse done_o and go to IDLE, or to SETUP per Configuration.
- mosi_o is forced to 0 whenever cs_no=1.
- Bit counter width is clog2(DataWidth+1). It never wraps; it is cleared on every accept.
- Reset (any time, including mid-frame): state IDLE, cs_no=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, ready_o=1; shift register, counter and divider are cleared.
- div_i changes during a frame have no effect; the latched D applies until the next accept.

## Timing
- Accept at clock edge k: cs_no falls and busy_o rises at k+1.
- cs_no is low for D*(2*DataWidth+2) cycles.
- busy_o is high for D*(2*DataWidth+3) cycles.
- done_o is high in the first cycle after GAP, in the same cycle busy_o returns low.
- sclk_o period is 2D cycles with 50% duty. D=1 gives clk/2.
- Without the macro, ready_o = ~busy_o, and start_i while busy_o=1 is ignored.
- With start_i held high and no macro, frames repeat with one idle cycle between done_o and the next cs_no fall.

## Configuration
- SPI_WRITE_HOLD_REG_EN defined: adds a one-entry holding register (data and div).
  - ready_o = ~hold_valid.
  - start_i while busy loads the holding register.
  - At the end of GAP with hold_valid=1: done_o still pulses, hold_valid clears, and the FSM enters SETUP directly. busy_o stays high and cs_no is high for exactly D cycles (the GAP) between frames.
  - In IDLE, accept goes directly to the shifter, not the holding register.
- SPI_WRITE_HOLD_REG_EN undefined: no holding register; behaviour as in Timing.

## Structure
- Shared package spi_write_pkg holds:
  - state encodings (3-bit localparams)
  - default DataWidth/DivWidth
  - SPI mode constant
- One sub-module, spi_half_tick: a down-counter reloaded with the latched div value. It emits a one-cycle tick on the last cycle of each D-cycle phase and is cleared by accept or reset.

## Test plan
- D=1, data 0xA5F00F: bits sampled on sclk_o rising edges equal 0xA5F00F MSB first; cs_no low 50 cycles; busy_o 51 cycles; done_o single pulse.
- div_i=3 (D=4), data 0x000001: sclk_o period 8 cycles; busy_o 204 cycles; only the last sampled bit is 1. Changing div_i mid-frame does not alter timing.
- Reset asserted after the 10th rising sclk edge: next cycle cs_no=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0; a following start sends the full word.
- No macro, start_i pulsed mid-frame with 0x123456: ignored; only the original word is sent and done_o pulses once.
- Macro on, D=2, words 0x111111 then 0x222222 (second given mid-frame): ready_o drops after the second accept; cs_no is high exactly 2 cycles between frames; done_o pulses twice; busy_o stays high throughout.
- start_i held high, no macro, D=1: consecutive frames separated by exactly one IDLE cycle with busy_o=0.
